// File: rtl/pc_sequencer.sv
// Program-counter controller: the PC register, a small return-address stack and a
// run/halt/fault state machine that gates all PC movement.
module pc_sequencer #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int STACK_DEPTH   = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = {ADDRESS_WIDTH{1'b0}}
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               halt,
    input  logic                               step,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDRESS_WIDTH-1:0]           target,
    output logic [ADDRESS_WIDTH-1:0]           pc_out,
    output logic                               running,
    output logic                               fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic [ADDRESS_WIDTH-1:0] pc_nxt_s;
    logic [ADDRESS_WIDTH-1:0] inc_s;
    logic [ADDRESS_WIDTH-1:0] top_s;
    logic [DW-1:0]            depth_r;
    logic [DW-1:0]            depth_nxt_s;
    logic                     push_s;
    logic                     running_r;
    logic                     fault_r;
    logic [ADDRESS_WIDTH-1:0] stack_r [STACK_DEPTH];

    // Carry is discarded, so the max address wraps to zero (also for pushed returns).
    assign inc_s = pc_r + ADDRESS_WIDTH'(1);

    // Top-of-stack read: the entry just below the occupancy pointer.
    always_comb begin
        top_s = {ADDRESS_WIDTH{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_r == DW'(i + 1)) begin
                top_s = stack_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Next-state and datapath decisions; in RUN one action per cycle, halt first.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        depth_nxt_s = depth_r;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (ret) begin
                    if (depth_r != {DW{1'b0}}) begin
                        pc_nxt_s    = top_s;
                        depth_nxt_s = depth_r - DEPTH_ONE;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end else if (call) begin
                    if (depth_r < DEPTH_FULL) begin
                        push_s      = 1'b1;
                        pc_nxt_s    = target;
                        depth_nxt_s = depth_r + DEPTH_ONE;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end else if (jump) begin
                    pc_nxt_s = target;
                end else if (step) begin
                    pc_nxt_s = inc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_HALT: begin
                if (start && !halt) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_FAULT;
            end
        endcase
    end

    // State, PC, stack and registered status flags; reset discards the stack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_ADDRESS;
            depth_r   <= {DW{1'b0}};
            running_r <= 1'b0;
            fault_r   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {ADDRESS_WIDTH{1'b0}};
            end
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            depth_r   <= depth_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            fault_r   <= (state_nxt_s == ST_FAULT);
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push_s && (depth_r == DW'(i))) begin
                    stack_r[i] <= inc_s;
                end
            end
        end
    end

    assign pc_out  = pc_r;
    assign depth   = depth_r;
    assign running = running_r;
    assign fault   = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table for the corner cases, then random
// commands checked against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start, halt, step, jump, call, ret;
    logic [10:0] target;
    logic [10:0] pc_out;
    logic        running, fault;
    logic [2:0]  depth;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt), .step(step),
        .jump(jump), .call(call), .ret(ret), .target(target),
        .pc_out(pc_out), .running(running), .fault(fault), .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain mode number, integer PC, queue as the stack
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
    int m_mode = M_IDLE;
    int m_pc   = 0;
    int m_stack[$];

    task automatic model_apply(input logic r_n, input logic st, input logic ht, input logic sp,
                               input logic jp, input logic cl, input logic rt, input int tgt);
        if (!r_n) begin
            m_mode = M_IDLE;
            m_pc   = 0;
            m_stack.delete();
        end else if (m_mode == M_IDLE) begin
            if (st) m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (st && !ht) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (ht) m_mode = M_HALT;
            else if (rt) begin
                if (m_stack.size() == 0) m_mode = M_FAULT;
                else m_pc = m_stack.pop_back();
            end else if (cl) begin
                if (m_stack.size() == 4) m_mode = M_FAULT;
                else begin
                    m_stack.push_back((m_pc + 1) % 2048);
                    m_pc = tgt;
                end
            end else if (jp) m_pc = tgt;
            else if (sp) m_pc = (m_pc + 1) % 2048;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic apply(input logic r_n, input logic st, input logic ht, input logic sp,
                         input logic jp, input logic cl, input logic rt, input logic [10:0] tgt);
        reset_n = r_n; start = st; halt = ht; step = sp;
        jump = jp; call = cl; ret = rt; target = tgt;
        @(posedge clk);
        model_apply(r_n, st, ht, sp, jp, cl, rt, int'(tgt));
        #1;
    endtask

    typedef struct {
        logic        r_n, st, ht, sp, jp, cl, rt;
        logic [10:0] tgt;
        logic [10:0] e_pc;
        logic        e_run, e_flt;
        logic [2:0]  e_dep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r_n, input logic st, input logic ht, input logic sp,
                                input logic jp, input logic cl, input logic rt, input logic [10:0] tgt,
                                input logic [10:0] e_pc, input logic e_run, input logic e_flt,
                                input logic [2:0] e_dep);
        vec_t v;
        v.r_n = r_n; v.st = st; v.ht = ht; v.sp = sp; v.jp = jp; v.cl = cl; v.rt = rt;
        v.tgt = tgt; v.e_pc = e_pc; v.e_run = e_run; v.e_flt = e_flt; v.e_dep = e_dep;
        return v;
    endfunction

    initial begin
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; step = 1'b0;
        jump = 1'b0; call = 1'b0; ret = 1'b0; target = 11'h000;

        //               rn st ht sp jp cl rt  tgt       pc      run flt dep
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 11'h000, 11'h000, 0, 0, 3'd0)); // reset
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h000, 0, 0, 3'd0)); // step ignored in IDLE
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 11'h000, 11'h000, 1, 0, 3'd0)); // start
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h001, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h002, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h003, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h004, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 11'h005, 11'h005, 1, 0, 3'd0)); // jump 5
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h100, 11'h100, 1, 0, 3'd1)); // nested call/ret
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h200, 11'h200, 1, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 11'h000, 11'h101, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 11'h000, 11'h006, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 11'h000, 11'h006, 0, 0, 3'd0)); // halt+step
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h006, 0, 0, 3'd0)); // step in HALT
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 11'h000, 11'h006, 0, 0, 3'd0)); // halt+start stays
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 11'h000, 11'h006, 1, 0, 3'd0)); // resume
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h007, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 11'h040, 11'h040, 1, 0, 3'd1)); // call beats jump
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 11'h7FF, 11'h7FF, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h000, 1, 0, 3'd1)); // wrap
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 11'h7FF, 11'h7FF, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h010, 11'h010, 1, 0, 3'd2)); // pushes 0
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 11'h000, 11'h000, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 11'h000, 11'h008, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 11'h000, 11'h008, 0, 1, 3'd0)); // underflow
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h008, 0, 1, 3'd0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 11'h000, 11'h008, 0, 1, 3'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'h000, 11'h000, 0, 0, 3'd0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 11'h000, 11'h000, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h010, 11'h010, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h020, 11'h020, 1, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h030, 11'h030, 1, 0, 3'd3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h040, 11'h040, 1, 0, 3'd4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h050, 11'h040, 0, 1, 3'd4)); // overflow
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 11'h000, 11'h040, 0, 1, 3'd4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 11'h000, 11'h000, 0, 0, 3'd0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 11'h000, 11'h000, 1, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h100, 11'h100, 1, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h200, 11'h200, 1, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 11'h300, 11'h300, 1, 0, 3'd3));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 11'h123, 11'h123, 1, 0, 3'd3));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 11'h000, 11'h000, 0, 0, 3'd0)); // reset mid-RUN

        foreach (vecs[i]) begin
            apply(vecs[i].r_n, vecs[i].st, vecs[i].ht, vecs[i].sp,
                  vecs[i].jp, vecs[i].cl, vecs[i].rt, vecs[i].tgt);
            check($sformatf("vec%0d pc_out", i), 32'(pc_out), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
            check($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].e_flt));
            check($sformatf("vec%0d depth", i), 32'(depth), 32'(vecs[i].e_dep));
        end

        // random phase against the reference model
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);
        for (int n = 0; n < 3000; n++) begin
            logic [10:0] t;
            t = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom);
            apply($urandom_range(0, 79) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  t);
            check("rnd pc_out", 32'(pc_out), 32'(m_pc));
            check("rnd running", 32'(running), 32'(m_mode == M_RUN));
            check("rnd fault", 32'(fault), 32'(m_mode == M_FAULT));
            check("rnd depth", 32'(depth), 32'(m_stack.size()));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
